// File: rtl/delay_line_sequencer.sv
// delay_line_sequencer: queues delay commands and drives the 32-tap delay line
// with a setup / trigger-pulse / hold sequence per command.
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_cmd_valid          command offered; accepted when o_cmd_ready is high
//   o_cmd_ready          command queue not full
//   i_cmd_delay          tap index N (0..31)
//   i_cmd_width          trigger high cycles (0 treated as 1)
//   i_cmd_invert         invert the generated tap pattern
//   i_flush              synchronous abort: empty queue, end active sequence
//   o_trigger            delay line trigger
//   o_data               delay line tap data pattern
//   o_busy               sequence active or queue non-empty
//   o_done               one-cycle pulse per completed sequence
//   o_fire_count         completed sequence count (wraps)
module delay_line_sequencer #(
    parameter int DEPTH   = 4,
    parameter int SETUP   = 2,
    parameter int HOLD    = 4,
    parameter int WIDTH_W = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [4:0]         i_cmd_delay,
    input  logic [WIDTH_W-1:0] i_cmd_width,
    input  logic               i_cmd_invert,
    input  logic               i_flush,
    output logic               o_trigger,
    output logic [31:0]        o_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [15:0]        o_fire_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, FIRE, GAP, DONE} state_t;

    state_t               r_state, w_state_n;
    logic [31:0]          r_cnt, w_cnt_n;
    logic [31:0]          r_data, w_data_n;
    logic [WIDTH_W-1:0]   r_width, w_width_n;
    logic [15:0]          r_fire_count;
    logic [WIDTH_W+5:0]   r_mem [DEPTH];
    logic [AW-1:0]        r_wp, r_rp;
    logic [AW:0]          r_count, w_count_n;
    logic                 r_ready;
    logic                 w_push, w_pop, w_inc;
    logic [4:0]           w_head_delay;
    logic [WIDTH_W-1:0]   w_head_width;
    logic                 w_head_inv;

    assign w_push = i_cmd_valid & r_ready & ~i_flush;
    assign {w_head_inv, w_head_width, w_head_delay} = r_mem[r_rp];
    assign w_count_n = i_flush ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_data_n  = r_data;
        w_width_n = r_width;
        w_pop     = 1'b0;
        w_inc     = 1'b0;
        if (i_flush)
            w_state_n = IDLE;
        else
            case (r_state)
                // DONE always lasts one cycle; its exit edge may already pop the
                // next command so back-to-back data updates on the edge after DONE
                IDLE, DONE: begin
                    w_state_n = IDLE;
                    if (|r_count) begin
                        w_pop     = 1'b1;
                        w_state_n = LOAD;
                        w_cnt_n   = SETUP - 1;
                        w_width_n = (w_head_width == '0) ? WIDTH_W'(1) : w_head_width;
                        w_data_n  = (32'hFFFF_FFFF << w_head_delay) ^ {32{w_head_inv}};
                    end
                end
                LOAD: begin
                    w_cnt_n = r_cnt - 1;
                    if (r_cnt == 0) begin
                        w_state_n = FIRE;
                        w_cnt_n   = 32'(r_width) - 1;
                    end
                end
                FIRE: begin
                    w_cnt_n = r_cnt - 1;
                    if (r_cnt == 0) begin
                        w_state_n = GAP;
                        w_cnt_n   = HOLD - 1;
                    end
                end
                GAP: begin
                    w_cnt_n = r_cnt - 1;
                    if (r_cnt == 0) begin
                        w_state_n = DONE;
                        w_inc     = 1'b1;
                    end
                end
                default: w_state_n = IDLE;
            endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_data       <= '0;
            r_width      <= '0;
            r_fire_count <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_ready      <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_data  <= w_data_n;
            r_width <= w_width_n;
            r_count <= w_count_n;
            r_ready <= w_count_n != (AW+1)'(DEPTH);
            if (w_inc)
                r_fire_count <= r_fire_count + 16'd1;
            if (i_flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push)
                    r_wp <= r_wp + 1'b1;
                if (w_pop)
                    r_rp <= r_rp + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk)
        if (w_push)
            r_mem[r_wp] <= {i_cmd_invert, i_cmd_width, i_cmd_delay};

    assign o_cmd_ready  = r_ready;
    assign o_trigger    = r_state == FIRE;
    assign o_done       = r_state == DONE;
    assign o_data       = r_data;
    assign o_busy       = (r_state != IDLE) | (|r_count);
    assign o_fire_count = r_fire_count;
endmodule

// File: tb/tb_delay_line_sequencer.sv
// tb_delay_line_sequencer: scoreboard bench for delay_line_sequencer
module tb_delay_line_sequencer;
    localparam int DEPTH = 4, SETUP = 2, HOLD = 4, WIDTH_W = 8;

    logic               clk = 1'b0, rst = 1'b1;
    logic               cmd_valid = 1'b0, cmd_ready;
    logic [4:0]         cmd_delay = '0;
    logic [WIDTH_W-1:0] cmd_width = '0;
    logic               cmd_inv = 1'b0, flush = 1'b0;
    logic               trig, busy, done;
    logic [31:0]        data;
    logic [15:0]        fire_count;

    typedef struct {logic [31:0] data; int w;} exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    delay_line_sequencer #(.DEPTH(DEPTH), .SETUP(SETUP), .HOLD(HOLD), .WIDTH_W(WIDTH_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_delay(cmd_delay), .i_cmd_width(cmd_width), .i_cmd_invert(cmd_inv),
        .i_flush(flush), .o_trigger(trig), .o_data(data), .o_busy(busy),
        .o_done(done), .o_fire_count(fire_count));

    function automatic logic [31:0] pattern(input int n, input logic inv);
        logic [31:0] p;
        for (int k = 0; k < 32; k++) p[k] = (k >= n) ^ inv;
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard feed: commands taken at the coming edge become expectations
    always @(negedge clk) begin
        exp_t e;
        if (rst || flush) exp_q.delete();
        else if (cmd_valid && cmd_ready) begin
            e.data = pattern(int'(cmd_delay), cmd_inv);
            e.w = (cmd_width == 0) ? 1 : int'(cmd_width);
            exp_q.push_back(e);
        end
    end

    // monitor: checks each trigger pulse, its data, width, hold gap and done
    bit prev_trig = 0, active = 0, in_gap = 0;
    int hi = 0, gap = 0, fc_model = 0, exp_w = 0;
    logic [31:0] fire_data = '0;
    always @(negedge clk) begin
        exp_t cur;
        if (rst) begin
            prev_trig = 0; active = 0; in_gap = 0; fc_model = 0;
        end else begin
            if (trig && !prev_trig) begin
                chk("fire_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    chk("fire_data", data, cur.data);
                    exp_w = cur.w; fire_data = data; hi = 1; active = 1;
                end
            end else if (trig) begin
                hi++;
                chk("data_stable", data, fire_data);
            end else if (prev_trig && active) begin
                chk("trig_width", hi, exp_w);
                active = 0; in_gap = 1; gap = 0;
            end else if (in_gap) gap++;
            if (done) begin
                chk("done_after_gap", 32'(in_gap), 1);
                if (in_gap) begin
                    chk("hold_len", gap, HOLD);
                    fc_model++;
                    chk("fire_count", 32'(fire_count), 32'(16'(fc_model)));
                end
                in_gap = 0;
            end
            if (flush) begin active = 0; in_gap = 0; end
            prev_trig = trig;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push_cmd(input logic [4:0] d, input logic [7:0] w, input logic inv, output int waited);
        logic rdy;
        cmd_valid = 1; cmd_delay = d; cmd_width = w; cmd_inv = inv; waited = 0;
        do begin
            @(negedge clk); rdy = cmd_ready;
            tick();
            if (!rdy) waited++;
        end while (!rdy && waited < 500);
        chk("push_accept", 32'(rdy), 1);
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin tick(); n++; end
        chk("idle_reached", 32'(busy), 0);
        tick();
    endtask

    task automatic wait_trig();
        int n = 0;
        while (!trig && n < 200) begin tick(); n++; end
        chk("trig_seen", 32'(trig), 1);
    endtask

    initial begin
        int wt, n;
        logic [15:0] snap_fc;
        logic [31:0] snap_data;
        repeat (3) tick();
        chk("rst_trigger", 32'(trig), 0);
        chk("rst_data", data, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fire_count", 32'(fire_count), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        rst = 0;
        tick();

        // single command latency: N=5, width=3
        push_cmd(5'd5, 8'd3, 1'b0, wt);
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) chk("lat_data", data, 32'hFFFF_FFE0);
            if (c == 2 || c == 6) chk("lat_trig_low", 32'(trig), 0);
            if (c == 3 || c == 5) chk("lat_trig_high", 32'(trig), 1);
            if (c == 9 || c == 11) chk("lat_done_low", 32'(done), 0);
            if (c == 10) begin
                chk("lat_done_high", 32'(done), 1);
                chk("lat_fire_count", 32'(fire_count), 1);
            end
            if (c == 11) chk("lat_busy_low", 32'(busy), 0);
        end

        // pattern corners and zero width
        push_cmd(5'd0, 8'd1, 1'b0, wt);
        push_cmd(5'd31, 8'd2, 1'b1, wt);
        push_cmd(5'd7, 8'd0, 1'b0, wt);
        wait_idle();

        // fill the queue while the first command runs
        for (int i = 0; i < 5; i++) push_cmd(5'(3 * i + 1), 8'd3, 1'(i), wt);
        chk("full_not_ready", 32'(cmd_ready), 0);
        push_cmd(5'd30, 8'd2, 1'b0, wt);
        chk("sixth_held", 32'(wt > 0), 1);
        wait_idle();
        chk("sb_drained_fill", exp_q.size(), 0);

        // push coinciding with the pop that follows DONE at count DEPTH-1
        push_cmd(5'd9, 8'd4, 1'b0, wt);
        for (int i = 0; i < 3; i++) push_cmd(5'(10 + i), 8'd1, 1'b1, wt);
        n = 0;
        while (!done && n < 100) begin tick(); n++; end
        chk("done_seen", 32'(done), 1);
        cmd_valid = 1; cmd_delay = 5'd13; cmd_width = 8'd2; cmd_inv = 1'b0;
        tick();
        cmd_valid = 0;
        chk("pushpop_ready", 32'(cmd_ready), 1);
        push_cmd(5'd14, 8'd1, 1'b0, wt);
        chk("pushpop_count", 32'(cmd_ready), 0);
        wait_idle();
        chk("sb_drained_pushpop", exp_q.size(), 0);

        // flush during FIRE with two queued and a push in the flush cycle
        push_cmd(5'd3, 8'd20, 1'b0, wt);
        push_cmd(5'd4, 8'd2, 1'b0, wt);
        push_cmd(5'd5, 8'd2, 1'b1, wt);
        wait_trig();
        repeat (2) tick();
        snap_fc = fire_count;
        snap_data = data;
        flush = 1; cmd_valid = 1; cmd_delay = 5'd20; cmd_width = 8'd1;
        tick();
        flush = 0; cmd_valid = 0;
        chk("flush_trig", 32'(trig), 0);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_done", 32'(done), 0);
        chk("flush_fire_count", 32'(fire_count), 32'(snap_fc));
        chk("flush_data", data, snap_data);
        chk("flush_ready", 32'(cmd_ready), 1);
        repeat (30) tick();
        chk("flush_stays_idle", 32'(busy), 0);

        // randomized traffic
        for (int i = 0; i < 150; i++) begin
            push_cmd(5'($urandom_range(0, 31)), 8'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), wt);
            repeat ($urandom_range(0, 12)) tick();
        end
        wait_idle();
        chk("sb_drained_random", exp_q.size(), 0);

        // asynchronous reset mid-FIRE
        push_cmd(5'd17, 8'd10, 1'b0, wt);
        wait_trig();
        repeat (2) tick();
        #2 rst = 1;
        #1;
        chk("arst_trig", 32'(trig), 0);
        chk("arst_data", data, 0);
        chk("arst_fire_count", 32'(fire_count), 0);
        chk("arst_ready", 32'(cmd_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        tick();
        rst = 0;
        tick();
        push_cmd(5'd2, 8'd2, 1'b0, wt);
        wait_idle();
        chk("post_rst_count", 32'(fire_count), 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
